// File: rtl/float_conv_pkg.sv
// Shared definitions for the float <-> decimal converters: FSM states,
// IEEE 754 single-precision field layout and exponent constants.
package float_conv_pkg;

  localparam int unsigned FLOAT_W     = 32;
  localparam int unsigned EXP_W       = 8;
  localparam int unsigned MAN_W       = 23;
  localparam int unsigned SIGN_POS    = 31;
  localparam int unsigned EXP_MSB     = 30;
  localparam int unsigned EXP_LSB     = 23;
  localparam int unsigned MAN_MSB     = 22;
  localparam int unsigned EXP_BIAS    = 127;
  localparam int unsigned EXP_SPECIAL = 255;

  // Largest biased exponent whose integer part still fits in 32 bits (e = 31).
  localparam int unsigned EXP_INT_MAX = EXP_BIAS + 31;
  // Below this biased exponent (e < -32) nothing survives above 2^-32.
  localparam int unsigned EXP_TINY    = EXP_BIAS - 32;
  // Right-shift base that places {1,mantissa} into a 32.32 window.
  localparam int unsigned FIX_RSH_BASE = EXP_BIAS + 95;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    SHIFT,
    DIGIT,
    DONE
  } conv_state_e;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W-1:0]     exp;
    logic [MAN_W-1:0]     man;
  } ieee754_sp_t;

endpackage

// File: rtl/decimal_digit_step.sv
// One decimal-digit extraction step: multiplies a 0.32 binary fraction by ten,
// splitting the product into the next digit and the remaining fraction.
module decimal_digit_step
  import float_conv_pkg::*;
(
  input  logic [WORD_W-1:0]  i_frac,
  output logic [DIGIT_W-1:0] o_digit_c,
  output logic [WORD_W-1:0]  o_frac_c
);

  localparam int unsigned PROD_W = WORD_W + DIGIT_W;

  logic [PROD_W-1:0] w_prod;

  assign w_prod    = PROD_W'(i_frac) * PROD_W'(10);
  assign o_digit_c = w_prod[PROD_W-1:WORD_W];
  assign o_frac_c  = w_prod[WORD_W-1:0];

endmodule

// File: rtl/float_decimal_converter.sv
// Sequential IEEE 754 single -> sign / integer magnitude / truncated decimal
// fraction converter; emits one fraction digit per cycle behind valid/ready.
module float_decimal_converter
  import float_conv_pkg::*;
#(
  parameter int unsigned FRAC_DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       float_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [31:0]       int_out,
  output logic [31:0]       frac_out,
  output logic              overflow,
  output logic              invalid
);

  localparam int unsigned WIDE_W = 128;
  localparam int unsigned FIX_W  = 64;
  localparam int unsigned SH_W   = 7;

  conv_state_e r_state;
  conv_state_e w_state_next;

  ieee754_sp_t        r_float;
  logic [WORD_W-1:0]  r_int;
  logic [WORD_W-1:0]  r_frac;
  logic [WORD_W-1:0]  r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_sign;
  logic [WORD_W-1:0]  r_int_out;
  logic [WORD_W-1:0]  r_frac_out;
  logic               r_ovf;
  logic               r_inv;

  logic               w_accept;
  logic               w_handshake;
  logic               w_last_digit;
  logic               w_is_zero;
  logic               w_is_nan;
  logic               w_is_ovf;
  logic               w_special;
  logic               w_is_tiny;
  logic [WIDE_W-1:0]  w_wide;
  logic [SH_W-1:0]    w_rsh;
  logic [FIX_W-1:0]   w_fixed;
  logic [DIGIT_W-1:0] w_digit;
  logic [WORD_W-1:0]  w_frac_next;
  logic [WORD_W-1:0]  w_acc_next;

  logic               w_load_special;
  logic               w_load_fixed;
  logic               w_digit_en;
  logic               w_load_result;

  // Special-case classification of the captured operand
  assign w_is_zero = (r_float.exp == '0);
  assign w_is_nan  = (r_float.exp == EXP_W'(EXP_SPECIAL));
  assign w_is_ovf  = (r_float.exp > EXP_W'(EXP_INT_MAX)) && !w_is_nan;
  assign w_special = w_is_zero || w_is_nan || w_is_ovf;

  // {1,mantissa} at the top of a wide word, shifted down into a 32.32 window
  assign w_is_tiny = (r_float.exp < EXP_W'(EXP_TINY));
  assign w_wide    = {1'b1, r_float.man, (WIDE_W - MAN_W - 1)'(0)};
  assign w_rsh     = SH_W'(EXP_W'(FIX_RSH_BASE) - r_float.exp);
  assign w_fixed   = w_is_tiny ? '0 : FIX_W'(w_wide >> w_rsh);

  decimal_digit_step u_digit_step (
    .i_frac    (r_frac),
    .o_digit_c (w_digit),
    .o_frac_c  (w_frac_next)
  );

  assign w_acc_next   = (r_acc * WORD_W'(10)) + WORD_W'(w_digit);
  assign w_accept     = in_valid && r_in_ready;
  assign w_handshake  = r_out_valid && out_ready;
  assign w_last_digit = (r_cnt == CNT_W'(FRAC_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_load_special = 1'b0;
    w_load_fixed   = 1'b0;
    w_digit_en     = 1'b0;
    w_load_result  = 1'b0;
    case (r_state)
      IDLE:   if (w_accept) w_state_next = UNPACK;
      UNPACK: begin
        w_load_special = w_special;
        w_state_next   = w_special ? DONE : SHIFT;
      end
      SHIFT: begin
        w_load_fixed = 1'b1;
        w_state_next = DIGIT;
      end
      DIGIT: begin
        w_digit_en = 1'b1;
        if (w_last_digit) begin
          w_load_result = 1'b1;
          w_state_next  = DONE;
        end
      end
      DONE:    if (w_handshake) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs; results change only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_float     <= '0;
      r_int       <= '0;
      r_frac      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_int_out   <= '0;
      r_frac_out  <= '0;
      r_ovf       <= 1'b0;
      r_inv       <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == IDLE);
      r_out_valid <= (r_state == DONE) && !w_handshake;
      if (w_accept) r_float <= ieee754_sp_t'(float_in);
      if (w_load_special) begin
        r_sign     <= r_float.sign;
        r_int_out  <= (w_is_nan || w_is_ovf) ? '1 : '0;
        r_frac_out <= '0;
        r_ovf      <= w_is_ovf;
        r_inv      <= w_is_nan;
      end
      if (w_load_fixed) begin
        r_int  <= w_fixed[FIX_W-1:WORD_W];
        r_frac <= w_fixed[WORD_W-1:0];
        r_acc  <= '0;
        r_cnt  <= '0;
      end
      if (w_digit_en) begin
        r_frac <= w_frac_next;
        r_acc  <= w_acc_next;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (w_load_result) begin
        r_sign     <= r_float.sign;
        r_int_out  <= r_int;
        r_frac_out <= w_acc_next;
        r_ovf      <= 1'b0;
        r_inv      <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sign_out  = r_sign;
  assign int_out   = r_int_out;
  assign frac_out  = r_frac_out;
  assign overflow  = r_ovf;
  assign invalid   = r_inv;

endmodule

// File: tb/tb_float_decimal_converter.sv
// Directed bench for float_decimal_converter: hand-computed vectors plus an
// arithmetic reference model checked on every cycle a result is presented.
module tb_float_decimal_converter;

  localparam int unsigned FRAC_DIGITS = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] float_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [31:0] int_out;
  logic [31:0] frac_out;
  logic        overflow;
  logic        invalid;

  int          n_cmp;
  int          n_err;
  int          n_accept;
  logic [31:0] cur_in;

  float_decimal_converter #(.FRAC_DIGITS(FRAC_DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .float_in  (float_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .int_out   (int_out),
    .frac_out  (frac_out),
    .overflow  (overflow),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact value m * 2^(e-23), integer part and floor(frac * 10^D)
  function automatic logic [97:0] model(input logic [31:0] f);
    logic        s, ov, inv;
    logic [31:0] ip, fr;
    int          e, k;
    longint unsigned m, rem, f32, pw;
    s = f[31]; ov = 1'b0; inv = 1'b0; ip = '0; fr = '0;
    if (f[30:23] == 8'hFF) begin
      inv = 1'b1; ip = '1;
    end else if (f[30:23] != 8'h00) begin
      e = int'(f[30:23]) - 127;
      if (e > 31) begin
        ov = 1'b1; ip = '1;
      end else begin
        m = {40'd0, 1'b1, f[22:0]};
        if (e >= 23) begin
          ip  = 32'(m << (e - 23));
          f32 = 0;
        end else begin
          k   = 23 - e;
          ip  = 32'(m >> k);
          rem = m - ((m >> k) << k);
          f32 = (k <= 32) ? (rem << (32 - k)) : (rem >> (k - 32));
        end
        pw = 1;
        for (int d = 0; d < int'(FRAC_DIGITS); d++) pw = pw * 10;
        fr = 32'((f32 * pw) >> 32);
      end
    end
    return {s, ip, fr, ov, inv};
  endfunction

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      cur_in = float_in;
      n_accept++;
    end
  end

  // Whenever a result is presented it must match the model of the accepted input
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("model", 128'({sign_out, int_out, frac_out, overflow, invalid}), 128'(model(cur_in)));
      chk("in_ready while out_valid", 128'(in_ready), 128'(0));
    end
  end

  task automatic send(input logic [31:0] f);
    int k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("in_ready before send", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    float_in = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic await_valid(input string name, input int exp_lat);
    int k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk(name, 128'(k), 128'(exp_lat));
  endtask

  task automatic check_out(input string name, input logic s, input logic [31:0] ip,
                           input logic [31:0] fr, input logic ov, input logic iv);
    chk(name, 128'({sign_out, int_out, frac_out, overflow, invalid}), 128'({s, ip, fr, ov, iv}));
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string name, input logic [31:0] f, input int lat, input logic s,
                     input logic [31:0] ip, input logic [31:0] fr, input logic ov, input logic iv);
    send(f);
    await_valid({name, " latency"}, lat);
    check_out(name, s, ip, fr, ov, iv);
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc_before;
    n_cmp = 0; n_err = 0; n_accept = 0; cur_in = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; float_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 128'(in_ready), 128'(0));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    check_out("reset outputs", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle in_ready", 128'(in_ready), 128'(1));

    run("3.75",      32'h40700000, 7, 1'b0, 32'd3,          32'd7500, 1'b0, 1'b0);
    run("-0.5",      32'hBF000000, 7, 1'b1, 32'd0,          32'd5000, 1'b0, 1'b0);
    run("0.1",       32'h3DCCCCCD, 7, 1'b0, 32'd0,          32'd1000, 1'b0, 1'b0);
    run("zero",      32'h00000000, 2, 1'b0, 32'd0,          32'd0,    1'b0, 1'b0);
    run("denormal",  32'h00000001, 2, 1'b0, 32'd0,          32'd0,    1'b0, 1'b0);
    run("+inf",      32'h7F800000, 2, 1'b0, 32'hFFFFFFFF,   32'd0,    1'b0, 1'b1);
    run("1e10",      32'h501502F9, 2, 1'b0, 32'hFFFFFFFF,   32'd0,    1'b1, 1'b0);
    run("int max",   32'h4F7FFFFF, 7, 1'b0, 32'd4294967040, 32'd0,    1'b0, 1'b0);
    run("123.456",   32'h42F6E979, 7, 1'b0, 32'd123,        32'd4560, 1'b0, 1'b0);
    run("-123.456",  32'hC2F6E979, 7, 1'b1, 32'd123,        32'd4560, 1'b0, 1'b0);

    // Backpressure: hold result, ignore a competing request, then resume
    send(32'h40700000);
    await_valid("bp latency", 7);
    acc_before = n_accept;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin in_valid = 1'b1; float_in = 32'h3F800000; end
      if (c == 6) in_valid = 1'b0;
      check_out("bp hold", 1'b0, 32'd3, 32'd7500, 1'b0, 1'b0);
      chk("bp out_valid", 128'(out_valid), 128'(1));
      chk("bp in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
    end
    chk("bp busy request ignored", 128'(n_accept), 128'(acc_before));
    ack();
    chk("post-handshake in_ready", 128'(in_ready), 128'(1));
    chk("post-handshake out_valid", 128'(out_valid), 128'(0));
    run("2.0 after bp", 32'h40000000, 7, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0);

    // Asynchronous reset while digits are being produced
    send(32'hC2F6E979);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset in_ready", 128'(in_ready), 128'(0));
    chk("midreset out_valid", 128'(out_valid), 128'(0));
    check_out("midreset outputs", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("3.75 after reset", 32'h40700000, 7, 1'b0, 32'd3, 32'd7500, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
